nios2_system_pio_button: RTL and testbench
==========================================

Name: nios2_system_pio_button

Overview:
Avalon-MM slave input PIO, the read-side counterpart of the LED output PIO on the same Nios II system bus. It samples WIDTH asynchronous board inputs (push buttons or DIP switches) through a 2-FF synchronizer and a per-bit debounce counter. It latches selected edges in a write-1-to-clear edge-capture register and raises a level interrupt to the CPU for unmasked captured edges.

Parameters:
WIDTH, 8, number of input bits (1..32)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles before a debounced bit changes (>=1)
EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge of the debounced value
RESET_VALUE, 0, reset value of the synchronizer and debounced registers (WIDTH bits)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon word address
chipselect  input  1  Avalon chip select
read_n  input  1  Avalon read strobe, active low
write_n  input  1  Avalon write strobe, active low
writedata  input  32  Avalon write data
in_port  input  WIDTH  asynchronous external inputs
readdata  output  32  Avalon read data, registered, read latency 1
irq  output  1  level interrupt request, active high

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous, active low. Every register clears or presets on reset_n low, independent of clk.
- Reset values:
  - sync1, sync2, db_value = RESET_VALUE
  - debounce counters = 0
  - irq_mask = 0
  - edge_capture = 0
  - readdata = 0
  - irq = 0
- Synchronizer: sync1 <= in_port; sync2 <= sync1. Only sync2 is used downstream.
- Debounce, per bit i:
  - If sync2[i] == db_value[i]: counter[i] <= 0.
  - Otherwise counter[i] increments.
  - When counter[i] == DEBOUNCE_CYCLES-1 and sync2[i] still differs: db_value[i] <= sync2[i] and counter[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches db_value.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1. The counter never wraps.
- Edge detection: db_prev <= db_value every cycle.
  - rise = db_value & ~db_prev
  - fall = ~db_value & db_prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
- Register map (address):
  - 0: data, read-only. readdata[WIDTH-1:0] = db_value. Writes are ignored.
  - 1: direction, reads 0. Writes are ignored.
  - 2: irq_mask, read/write, WIDTH bits. Written from writedata[WIDTH-1:0] when chipselect && !write_n.
  - 3: edge_capture, read / write-1-to-clear.
- Read timing: when chipselect && !read_n, readdata is loaded on that clk edge with the addressed value and held until the next read. Unused upper bits are 0.
- Edge-capture update each cycle: edge_capture <= (edge_capture & ~clr) | edge_detect.
  - clr = writedata[WIDTH-1:0] when a write to address 3 is in progress, else 0.
  - An edge detected in the same cycle as a clear of that bit wins: the bit remains 1.
  - Captured bits are sticky until cleared.
- Interrupt: irq is registered, irq <= |(edge_capture_next & irq_mask_next), so irq follows its cause by 1 cycle.
  - Clearing the last pending unmasked bit drops irq one cycle after the write.
  - Writing mask 0 with edges pending drops irq one cycle after the write.
- Latency, in_port change to edge_capture set: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles. irq follows edge_capture by 0 additional cycles.
- Simultaneous read and write in one cycle (out-of-protocol): the write takes effect. readdata returns the pre-write register value.
- Reset mid-debounce: the counter is discarded and db_value returns to RESET_VALUE. No edge is generated by reset release.

Test Plan:
- Reset: assert reset_n=0 with in_port=8'hFF. Require readdata=0, irq=0, and a read of address 0 to return 0x00. Release reset. After 2+4 cycles a read of address 0 returns 0xFF, with EDGE_TYPE=0 and rising edges captured.
- Debounce: pulse in_port[0] high for 3 cycles with DEBOUNCE_CYCLES=4. Require db_value unchanged and edge_capture=0. Then hold it high for 4 cycles. Require data bit 0 = 1 and edge_capture=0x01 exactly 7 cycles after the input change.
- Interrupt/mask: write address 2 = 0x05, then create an edge on bit 1. Require irq=0. Create an edge on bit 2. Require irq=1 and edge_capture reading 0x06.
- W1C: with edge_capture=0x06, write address 3 = 0x04. Require edge_capture=0x02 and irq=0 one cycle after the write. Write 0x02. Require 0x00.
- Simultaneous: time a bit-0 edge to land in the same cycle as a write of 0x01 to address 3. Require edge_capture bit 0 = 1 afterwards.
- Read latency: read address 1 and address 0 back-to-back. Require 0x00000000, then the data value, each one cycle after its read strobe. Upper 24 bits are always 0.

Source files
------------

// File: rtl/nios2_system_pio_button.sv
// nios2_system_pio_button: Avalon-MM input PIO with 2-FF synchronizer, per-bit debounce, edge capture and masked irq
//   clk, reset_n       : system clock, asynchronous active-low reset
//   address            : word address (0 data, 1 direction, 2 irq_mask, 3 edge_capture W1C)
//   chipselect         : Avalon chip select
//   read_n, write_n    : Avalon strobes, active low
//   writedata          : Avalon write data
//   in_port            : asynchronous board inputs
//   readdata           : registered read data, latency 1, held between reads
//   irq                : registered level interrupt for unmasked captured edges
module nios2_system_pio_button #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]         sync1_q, sync2_q, db_q, db_d, db_prev_q;
    logic [WIDTH-1:0]         mask_q, mask_d, ec_q, ec_d;
    logic [WIDTH-1:0]         rise, fall, edge_det, clr;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [31:0]              readdata_q, readdata_d, rd_mux;
    logic                     irq_q, irq_d, wr, rd;
    logic                     unused_wd;

    assign unused_wd = ^writedata;
    assign readdata  = readdata_q;
    assign irq       = irq_q;

    always_comb begin
        wr = chipselect && !write_n;
        rd = chipselect && !read_n;
        // a bit changes only after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count
        for (int i = 0; i < WIDTH; i++) begin
            db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] == CNT_LAST) ? sync2_q[i] : db_q[i];
            cnt_d[i] = (sync2_q[i] != db_q[i] && cnt_q[i] != CNT_LAST) ? cnt_q[i] + CW'(1) : '0;
        end
        rise       = db_q & ~db_prev_q;
        fall       = ~db_q & db_prev_q;
        edge_det   = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);
        clr        = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        mask_d     = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        // OR-ing the new edge after the clear lets a same-cycle edge win over W1C
        ec_d       = (ec_q & ~clr) | edge_det;
        irq_d      = |(ec_d & mask_d);
        rd_mux     = (address == 2'd0) ? 32'(db_q) :
                     (address == 2'd2) ? 32'(mask_q) :
                     (address == 2'd3) ? 32'(ec_q) : 32'd0;
        readdata_d = rd ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= RESET_VALUE;
            sync2_q    <= RESET_VALUE;
            db_q       <= RESET_VALUE;
            db_prev_q  <= RESET_VALUE;
            cnt_q      <= '0;
            mask_q     <= '0;
            ec_q       <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_prev_q  <= db_q;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            ec_q       <= ec_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_nios2_system_pio_button.sv
// tb_nios2_system_pio_button: directed plus randomized check of the input PIO against a sliding-window reference model
module tb_nios2_system_pio_button;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int ET = 0;

    logic           clk        = 1'b0;
    logic           reset_n    = 1'b0;
    logic [1:0]     address    = '0;
    logic           chipselect = 1'b0;
    logic           read_n     = 1'b1;
    logic           write_n    = 1'b1;
    logic [31:0]    writedata  = '0;
    logic [W-1:0]   in_port    = '1;
    logic [31:0]    readdata;
    logic           irq;

    int errors = 0;
    int checks = 0;

    nios2_system_pio_button #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET), .RESET_VALUE('0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // reference model: a bit flips once the last D synchronized samples all disagree with it
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_prev = '0, m_mask = '0, m_ec = '0;
    logic [W-1:0] m_hist [D];
    int           m_n = 0;
    logic [31:0]  m_rd = '0;
    logic         m_irq = 1'b0;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0; m_mask = '0; m_ec = '0;
        m_n = 0; m_rd = '0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] ndb, det, clr, nmask, nec;
        logic [31:0]  v;
        logic         flip;
        for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        if (m_n < D) m_n++;
        ndb = m_db;
        for (int i = 0; i < W; i++) begin
            flip = (m_n >= D);
            for (int k = 0; k < D; k++) if (m_hist[k][i] == m_db[i]) flip = 1'b0;
            if (flip) ndb[i] = ~m_db[i];
        end
        case (ET)
            0:       det = m_db & ~m_prev;
            1:       det = ~m_db & m_prev;
            default: det = m_db ^ m_prev;
        endcase
        clr   = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        nmask = (chipselect && !write_n && address == 2'd2) ? writedata[W-1:0] : m_mask;
        nec   = (m_ec & ~clr) | det;
        case (address)
            2'd0:    v = 32'(m_db);
            2'd2:    v = 32'(m_mask);
            2'd3:    v = 32'(m_ec);
            default: v = 32'd0;
        endcase
        if (chipselect && !read_n) m_rd = v;
        m_irq  = |(nec & nmask);
        m_prev = m_db;
        m_db   = ndb;
        m_s2   = m_s1;
        m_s1   = in_port;
        m_ec   = nec;
        m_mask = nmask;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if (readdata !== m_rd) begin
            errors++;
            $display("FAIL readdata: got %h expected %h at %0t", readdata, m_rd, $time);
        end
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq: got %b expected %b at %0t", irq, m_irq, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    initial begin
        logic [31:0] r;
        // reset with all inputs high
        tick();
        chk("reset_irq", 32'(irq), 32'd0);
        bus_read(2'd0, r);
        chk("reset_read_data", r, 32'h0);
        reset_n = 1'b1;
        repeat (6) tick();
        bus_read(2'd0, r);
        chk("post_reset_data", r, 32'hFF);
        bus_read(2'd3, r);
        chk("post_reset_edges", r, 32'hFF);
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3, r);
        chk("post_reset_clear", r, 32'h00);
        // debounce: 3-cycle glitch rejected, 4-cycle level accepted
        in_port = 8'hFE;
        repeat (10) tick();
        in_port = 8'hFF;
        repeat (3) tick();
        in_port = 8'hFE;
        repeat (10) tick();
        bus_read(2'd0, r);
        chk("glitch_data", r, 32'hFE);
        bus_read(2'd3, r);
        chk("glitch_edges", r, 32'h00);
        in_port = 8'hFF;
        repeat (5) tick();
        bus_read(2'd0, r);
        chk("debounce_data_early", r, 32'hFE);
        bus_read(2'd3, r);
        chk("edge_cycle6", r, 32'h00);
        bus_read(2'd3, r);
        chk("edge_cycle7", r, 32'h01);
        bus_read(2'd0, r);
        chk("debounce_data", r, 32'hFF);
        bus_write(2'd3, 32'h01);
        // interrupt masking
        bus_write(2'd2, 32'h05);
        in_port = 8'hF9;
        repeat (10) tick();
        in_port = 8'hFB;
        repeat (10) tick();
        chk("masked_irq", 32'(irq), 32'd0);
        in_port = 8'hFF;
        repeat (10) tick();
        chk("unmasked_irq", 32'(irq), 32'd1);
        bus_read(2'd3, r);
        chk("edges_06", r, 32'h06);
        // write-1-to-clear
        bus_write(2'd3, 32'h04);
        chk("w1c_irq_drop", 32'(irq), 32'd0);
        bus_read(2'd3, r);
        chk("w1c_edges_02", r, 32'h02);
        bus_write(2'd3, 32'h02);
        bus_read(2'd3, r);
        chk("w1c_edges_00", r, 32'h00);
        // edge lands in the same cycle as its clear
        in_port = 8'hFE;
        repeat (10) tick();
        in_port = 8'hFF;
        repeat (6) tick();
        bus_write(2'd3, 32'h01);
        bus_read(2'd3, r);
        chk("edge_beats_clear", r, 32'h01);
        chk("pending_irq", 32'(irq), 32'd1);
        bus_write(2'd2, 32'h00);
        chk("mask_off_irq", 32'(irq), 32'd0);
        bus_write(2'd3, 32'hFF);
        // back-to-back reads
        chipselect = 1'b1; read_n = 1'b0; address = 2'd1;
        tick();
        chk("read_dir", readdata, 32'h0);
        address = 2'd0;
        tick();
        chk("read_data_b2b", readdata, 32'h000000FF);
        chipselect = 1'b0; read_n = 1'b1;
        // randomized traffic with one mid-run asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2 reset_n = 1'b0;
                repeat (3) tick();
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ W'($urandom & $urandom);
            chipselect = ($urandom_range(0, 3) != 0);
            read_n     = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            tick();
        end
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
